mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, the number of bus cycles without bus_ack before a transaction is aborted with error.
REQ-002 SHALL have ports clk (in, 1, sole clock) and reset_n (in, 1); one clock, reset asynchronous and active-low.
REQ-003 SHALL have fe_req (in, 1), fe_addr (in, 30, word address [31:2]), fe_ack (out, 1), fe_error (out, 1) and fe_data (out, 32): the instruction-fetch port.
REQ-004 SHALL have mem_req (in, 1), mem_addr (in, 32), mem_write (in, 1), mem_data_in (in, 32, store data), mem_extend (in, 1, 1 = sign-extend load), mem_width (in, 2), mem_ack (out, 1), mem_error (out, 1) and mem_data_out (out, 32, load data): the data port.
REQ-005 SHALL have bus_req (out, 1), bus_addr (out, 30, word address), bus_write (out, 1), bus_be (out, 4, byte enables), bus_wdata (out, 32), bus_ack (in, 1), bus_error (in, 1) and bus_rdata (in, 32): the single word-wide backing bus.

Function
REQ-006 SHALL implement states IDLE, BUSY_FE, BUSY_MEM and RESP.
REQ-007 In IDLE, mem_req SHALL win over fe_req when both are high in the same cycle (fixed priority).
REQ-008 In IDLE, a granted request SHALL latch all port inputs and enter BUSY_x, with bus_req high from the next cycle (1-cycle issue latency).
REQ-009 In BUSY_x, bus_req and all bus_* outputs SHALL remain stable until a cycle where bus_ack=1; that cycle SHALL register read data and error, then go to RESP.
REQ-010 RESP SHALL last exactly one cycle: the granted port's ack=1, error=registered value, data valid; the other port's ack=0; then go to IDLE.
REQ-011 No request SHALL be sampled in RESP, so a requester dropping req the cycle after ack is never re-served.
REQ-012 mem_width encoding: 0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-013 A reserved width, a half access with mem_addr[0]=1, or a word access with mem_addr[1:0]!=0 SHALL go IDLE->RESP with mem_error=1 and no bus_req.
REQ-014 Stores SHALL replicate data to the lanes selected by mem_addr[1:0]: bus_be=0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word).
REQ-015 Loads SHALL drive bus_be as for stores, then extract the addressed byte/half from bus_rdata and sign-extend (mem_extend=1) or zero-extend it to 32 bits.
REQ-016 Fetches SHALL drive bus_be=1111 and bus_write=0, and return bus_rdata unmodified on fe_data.
REQ-017 A counter SHALL count BUSY_x cycles; on reaching TIMEOUT_CYCLES without bus_ack, the block SHALL drop bus_req and go to RESP with error=1.
REQ-018 A bus_ack arriving in the same cycle as the timeout SHALL take precedence (normal completion).
REQ-019 bus_ack seen in IDLE or RESP SHALL be ignored.
REQ-020 fe_data and mem_data_out SHALL be 0 whenever the corresponding ack is 0.

Reset
REQ-021 On reset_n=0, the block SHALL immediately enter IDLE, abandon any outstanding transaction, and clear the timeout counter.
REQ-022 On reset_n=0, all outputs SHALL be 0: bus_req, bus_addr, bus_write, bus_be, bus_wdata, fe_ack, fe_error, fe_data, mem_ack, mem_error and mem_data_out.
REQ-023 The first request SHALL be sampled in the first cycle after reset_n rises.

Structure
REQ-024 The state enum arb_state_t and the width constants (WIDTH_B, WIDTH_H, WIDTH_W) SHALL live in the shared package riscv_pkg.
REQ-025 Load extraction/extension and store lane steering SHALL be one combinational sub-module, mem_align.

Verification
REQ-026 fe_req=1 with fe_addr=0x100, bus_ack one cycle later with bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_be=1111, then fe_ack=1 and fe_data=0xDEADBEEF for one cycle.
REQ-027 fe_req and mem_req both high in the same cycle -> mem granted first; fe served after mem's RESP cycle, with no cycle where both acks are 1.
REQ-028 Load byte at mem_addr=0x203, mem_extend=1, bus_rdata=0x80000000 -> bus_be=1000, mem_data_out=0xFFFFFF80; the same load with mem_extend=0 -> 0x00000080.
REQ-029 Store half at mem_addr=0x202 with mem_data_in=0x0000ABCD -> bus_be=1100, bus_wdata[31:16]=0xABCD; mem_addr=0x201 -> mem_error=1 and bus_req never asserted.
REQ-030 TIMEOUT_CYCLES=4, bus_ack held 0 -> bus_req high for 4 cycles, then mem_ack=1 and mem_error=1.
REQ-031 reset_n pulsed low mid-BUSY_MEM -> all outputs 0 asynchronously; a late bus_ack after reset is ignored; a new fe_req is served normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the memory arbiter slice.
//   arb_state_t            : arbiter FSM states
//   WIDTH_B/WIDTH_H/WIDTH_W: data-port access width encodings (3 is reserved)
//   misaligned()           : flags accesses that must be rejected without a bus cycle
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_FE  = 2'd1,
      BUSY_MEM = 2'd2,
      RESP     = 2'd3
   } arb_state_t;

   localparam logic [1:0] WIDTH_B = 2'd0;
   localparam logic [1:0] WIDTH_H = 2'd1;
   localparam logic [1:0] WIDTH_W = 2'd2;

   // Reserved width, odd half address, or word address not on a word boundary.
   function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
      logic bad;
      case (width)
         WIDTH_B: bad = 1'b0;
         WIDTH_H: bad = addr_lo[0];
         WIDTH_W: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering for the data port.
//   addr_lo    : byte offset within the word
//   width      : access width (WIDTH_B/H/W)
//   extend     : 1 = sign-extend loads, 0 = zero-extend
//   store_data : raw store data from the requester
//   rdata      : word read from the bus
//   be         : byte enables for the bus cycle
//   wdata      : store data replicated onto every lane
//   load_data  : addressed byte/half, shifted down and extended
module mem_align
   import riscv_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  width,
   input  logic        extend,
   input  logic [31:0] store_data,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [31:0] lane;

   always_comb begin
      be        = 4'b0000;
      wdata     = 32'h0;
      load_data = 32'h0;
      // Bring the addressed byte/half down to bit 0.
      lane      = rdata >> {addr_lo, 3'b000};
      case (width)
         WIDTH_B: begin
            be        = 4'b0001 << addr_lo;
            wdata     = {4{store_data[7:0]}};
            load_data = {{24{extend & lane[7]}}, lane[7:0]};
         end
         WIDTH_H: begin
            be        = 4'b0011 << addr_lo;
            wdata     = {2{store_data[15:0]}};
            load_data = {{16{extend & lane[15]}}, lane[15:0]};
         end
         WIDTH_W: begin
            be        = 4'b1111;
            wdata     = store_data;
            load_data = rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single word-wide bus.
//   clk, reset_n : clock, asynchronous active-low reset
//   fe_*         : instruction-fetch port (word address, always full-word read)
//   mem_*        : data port (byte/half/word loads and stores)
//   bus_*        : backing bus; outputs held stable from issue until bus_ack
// The data port has fixed priority. A transaction that sees no bus_ack within
// TIMEOUT_CYCLES bus cycles completes with error.
module mem_arbiter
   import riscv_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        fe_req,
   input  logic [29:0] fe_addr,
   output logic        fe_ack,
   output logic        fe_error,
   output logic [31:0] fe_data,
   input  logic        mem_req,
   input  logic [31:0] mem_addr,
   input  logic        mem_write,
   input  logic [31:0] mem_data_in,
   input  logic        mem_extend,
   input  logic [1:0]  mem_width,
   output logic        mem_ack,
   output logic        mem_error,
   output logic [31:0] mem_data_out,
   output logic        bus_req,
   output logic [29:0] bus_addr,
   output logic        bus_write,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic        bus_error,
   input  logic [31:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_t  state, state_nxt;
   logic        sel_fe_q;
   logic [31:0] addr_q;
   logic        write_q;
   logic        extend_q;
   logic [1:0]  width_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic [CW-1:0] cnt_q;

   logic        busy, grant_mem, grant_fe, mem_bad, tmo;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_load;

   assign busy      = (state == BUSY_FE) || (state == BUSY_MEM);
   assign grant_mem = (state == IDLE) && mem_req;
   assign grant_fe  = (state == IDLE) && !mem_req && fe_req;
   assign mem_bad   = misaligned(mem_width, mem_addr[1:0]);
   // A bus_ack in the last allowed cycle wins over the timeout.
   assign tmo       = busy && !bus_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (mem_req)     state_nxt = mem_bad ? RESP : BUSY_MEM;
            else if (fe_req) state_nxt = BUSY_FE;
         end
         BUSY_FE, BUSY_MEM: begin
            if (bus_ack || tmo) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, completion capture and timeout counting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_fe_q <= 1'b0;
         addr_q   <= 32'h0;
         write_q  <= 1'b0;
         extend_q <= 1'b0;
         width_q  <= WIDTH_W;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else if (grant_mem) begin
         sel_fe_q <= 1'b0;
         addr_q   <= mem_addr;
         write_q  <= mem_write;
         extend_q <= mem_extend;
         width_q  <= mem_width;
         wdata_q  <= mem_data_in;
         rdata_q  <= 32'h0;
         err_q    <= mem_bad;
         cnt_q    <= '0;
      end else if (grant_fe) begin
         sel_fe_q <= 1'b1;
         addr_q   <= {fe_addr, 2'b00};
         write_q  <= 1'b0;
         extend_q <= 1'b0;
         width_q  <= WIDTH_W;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else if (busy) begin
         if (bus_ack) begin
            rdata_q <= bus_rdata;
            err_q   <= bus_error;
         end else if (tmo) begin
            err_q   <= 1'b1;
         end else begin
            cnt_q   <= cnt_q + 1'b1;
         end
      end
   end

   mem_align u_align (
      .addr_lo    (addr_q[1:0]),
      .width      (width_q),
      .extend     (extend_q),
      .store_data (wdata_q),
      .rdata      (rdata_q),
      .be         (al_be),
      .wdata      (al_wdata),
      .load_data  (al_load)
   );

   // Bus outputs are decoded from registered state only, so they are stable
   // for the whole BUSY cycle and zero outside it (including during reset).
   assign bus_req   = busy;
   assign bus_addr  = busy ? addr_q[31:2] : 30'h0;
   assign bus_write = (state == BUSY_MEM) && write_q;
   assign bus_be    = busy ? al_be : 4'b0000;
   assign bus_wdata = bus_write ? al_wdata : 32'h0;

   assign fe_ack       = (state == RESP) && sel_fe_q;
   assign fe_error     = fe_ack && err_q;
   assign fe_data      = fe_ack ? rdata_q : 32'h0;
   assign mem_ack      = (state == RESP) && !sel_fe_q;
   assign mem_error    = mem_ack && err_q;
   assign mem_data_out = (mem_ack && !write_q) ? al_load : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
   import riscv_pkg::*;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        fe_req = 1'b0;
   logic [29:0] fe_addr = '0;
   logic        fe_ack, fe_error;
   logic [31:0] fe_data;
   logic        mem_req = 1'b0;
   logic [31:0] mem_addr = '0;
   logic        mem_write = 1'b0;
   logic [31:0] mem_data_in = '0;
   logic        mem_extend = 1'b0;
   logic [1:0]  mem_width = 2'd0;
   logic        mem_ack, mem_error;
   logic [31:0] mem_data_out;
   logic        bus_req, bus_write;
   logic [29:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack = 1'b0;
   logic        bus_error = 1'b0;
   logic [31:0] bus_rdata = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack), .fe_error(fe_error), .fe_data(fe_data),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_write(mem_write), .mem_data_in(mem_data_in),
      .mem_extend(mem_extend), .mem_width(mem_width), .mem_ack(mem_ack), .mem_error(mem_error),
      .mem_data_out(mem_data_out),
      .bus_req(bus_req), .bus_addr(bus_addr), .bus_write(bus_write), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_error(bus_error), .bus_rdata(bus_rdata)
   );

   typedef struct { bit is_fe; bit err; logic [31:0] data; } rsp_t;
   typedef struct { logic [29:0] addr; logic [3:0] be; logic wr; logic [31:0] wdata; } bus_t;
   typedef struct { int lat; logic [31:0] rdata; logic err; } ack_t;

   rsp_t rsp_q[$];
   bus_t bus_q[$];
   ack_t ack_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int bus_rises = 0;
   int req_len = 0;
   int last_len = 0;
   bit stray_ack = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus responder: acks after 'lat' busy cycles, using per-transaction params.
   int   busy_idx = 0;
   ack_t cur;
   always @(negedge clk) begin
      if (bus_req) begin
         if (busy_idx == 0) begin
            if (ack_q.size() > 0) cur = ack_q.pop_front();
            else begin cur.lat = 100000; cur.rdata = 32'h0; cur.err = 1'b0; end
         end
         bus_ack   = (busy_idx == cur.lat);
         bus_rdata = bus_ack ? cur.rdata : 32'h0;
         bus_error = bus_ack & cur.err;
         busy_idx++;
      end else begin
         bus_ack   = stray_ack;
         bus_rdata = stray_ack ? 32'hBAD0BAD0 : 32'h0;
         bus_error = 1'b0;
         busy_idx  = 0;
      end
   end

   // Monitor: scoreboard pops on every ack and on every bus issue.
   logic bus_req_d = 1'b0;
   bus_t snap;
   rsp_t r;
   bus_t b;
   always @(negedge clk) begin
      if (!reset_n) begin
         bus_req_d = 1'b0;
         req_len   = 0;
      end else begin
         if (fe_ack || mem_ack) begin
            if (rsp_q.size() == 0) check("unexpected_ack", {30'h0, fe_ack, mem_ack}, 32'h0);
            else begin
               r = rsp_q.pop_front();
               check("ack_port", {30'h0, fe_ack, mem_ack}, r.is_fe ? 32'h2 : 32'h1);
               check("ack_error", {31'h0, r.is_fe ? fe_error : mem_error}, {31'h0, r.err});
               check("ack_data", r.is_fe ? fe_data : mem_data_out, r.data);
               check("other_port_data", r.is_fe ? mem_data_out : fe_data, 32'h0);
            end
         end
         if (bus_req && !bus_req_d) begin
            bus_rises++;
            req_len = 1;
            snap = '{bus_addr, bus_be, bus_write, bus_wdata};
            if (bus_q.size() == 0) check("unexpected_bus_req", {31'h0, bus_req}, 32'h0);
            else begin
               b = bus_q.pop_front();
               check("bus_addr", {2'b0, bus_addr}, {2'b0, b.addr});
               check("bus_be", {28'h0, bus_be}, {28'h0, b.be});
               check("bus_write", {31'h0, bus_write}, {31'h0, b.wr});
               if (b.wr) check("bus_wdata", bus_wdata, b.wdata);
            end
         end else if (bus_req) begin
            req_len++;
            check("bus_stable", {bus_addr, bus_be, bus_write, bus_wdata[0]} ^ {snap.addr, snap.be, snap.wr, snap.wdata[0]}, 32'h0);
            check("bus_wdata_stable", bus_wdata, snap.wdata);
         end else if (bus_req_d) begin
            last_len = req_len;
         end
         bus_req_d = bus_req;
      end
   end

   task automatic wait_ack(input bit fe);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = fe ? fe_ack : mem_ack;
      end
      if (!seen) check("ack_timeout", {31'h0, fe ? fe_ack : mem_ack}, 32'h1);
   endtask

   task automatic fe_txn(input logic [29:0] a, input int lat, input logic [31:0] rd, input logic er);
      rsp_q.push_back('{1'b1, er, rd});
      bus_q.push_back('{a, 4'b1111, 1'b0, 32'h0});
      ack_q.push_back('{lat, rd, er});
      @(negedge clk);
      fe_req = 1'b1; fe_addr = a;
      wait_ack(1'b1);
      fe_req = 1'b0;
      @(negedge clk);
   endtask

   // bus_ok=0: expect immediate error, no bus cycle.
   task automatic mem_txn(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          input logic ext, input logic [1:0] w, input int lat,
                          input logic [31:0] rd, input bit bus_ok, input logic [3:0] be,
                          input logic [31:0] bwd, input logic exp_err, input logic [31:0] exp_d);
      rsp_q.push_back('{1'b0, exp_err, exp_d});
      if (bus_ok) begin
         bus_q.push_back('{a[31:2], be, wr, bwd});
         ack_q.push_back('{lat, rd, 1'b0});
      end
      @(negedge clk);
      mem_req = 1'b1; mem_addr = a; mem_write = wr; mem_data_in = wd;
      mem_extend = ext; mem_width = w;
      wait_ack(1'b0);
      mem_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   int rises0;
   initial begin
      // Reset state
      #12;
      check("rst_outs", {bus_req, bus_write, fe_ack, fe_error, mem_ack, mem_error, 26'h0}, 32'h0);
      check("rst_bus_addr", {2'b0, bus_addr}, 32'h0);
      check("rst_bus_be", {28'h0, bus_be}, 32'h0);
      check("rst_data", fe_data | mem_data_out | bus_wdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Fetch, ack in first bus cycle
      fe_txn(30'h100, 0, 32'hDEADBEEF, 1'b0);
      // Signed / unsigned byte load at 0x203
      mem_txn(32'h203, 0, 0, 1, WIDTH_B, 2, 32'h80000000, 1, 4'b1000, 0, 0, 32'hFFFFFF80);
      mem_txn(32'h203, 0, 0, 0, WIDTH_B, 0, 32'h80000000, 1, 4'b1000, 0, 0, 32'h00000080);
      // Half store, upper lanes
      mem_txn(32'h202, 1, 32'h0000ABCD, 0, WIDTH_H, 1, 0, 1, 4'b1100, 32'hABCDABCD, 0, 0);
      // Misaligned half store and reserved width: error, no bus cycle
      rises0 = bus_rises;
      mem_txn(32'h201, 1, 32'h0000ABCD, 0, WIDTH_H, 0, 0, 0, 0, 0, 1, 0);
      mem_txn(32'h204, 0, 0, 0, 2'd3, 0, 0, 0, 0, 0, 1, 0);
      check("no_bus_on_misalign", bus_rises, rises0);
      // Word store and signed half load
      mem_txn(32'h10, 1, 32'hCAFEF00D, 0, WIDTH_W, 0, 0, 1, 4'b1111, 32'hCAFEF00D, 0, 0);
      mem_txn(32'h206, 0, 0, 1, WIDTH_H, 1, 32'h80010000, 1, 4'b1100, 0, 0, 32'hFFFF8001);
      // Timeout: bus_req high for TMO cycles then error
      mem_txn(32'h300, 0, 0, 0, WIDTH_W, 100000, 0, 1, 4'b1111, 0, 1, 0);
      check("timeout_len", last_len, TMO);
      // Ack exactly on the timeout cycle completes normally
      mem_txn(32'h304, 0, 0, 0, WIDTH_W, TMO - 1, 32'h0BADF00D, 1, 4'b1111, 0, 0, 32'h0BADF00D);
      // Bus error on fetch
      fe_txn(30'h44, 1, 32'h00000055, 1'b1);

      // Simultaneous requests: mem first, then fetch
      rsp_q.push_back('{1'b0, 1'b0, 32'h00000034});
      rsp_q.push_back('{1'b1, 1'b0, 32'h12345678});
      bus_q.push_back('{30'h20, 4'b0010, 1'b0, 32'h0});
      bus_q.push_back('{30'h40, 4'b1111, 1'b0, 32'h0});
      ack_q.push_back('{1, 32'h00003400, 1'b0});
      ack_q.push_back('{0, 32'h12345678, 1'b0});
      @(negedge clk);
      mem_req = 1; mem_addr = 32'h81; mem_write = 0; mem_extend = 0; mem_width = WIDTH_B;
      fe_req = 1; fe_addr = 30'h40;
      for (int i = 0; i < 40 && fe_req; i++) begin
         @(negedge clk);
         if (mem_ack) mem_req = 1'b0;
         if (fe_ack) fe_req = 1'b0;
      end
      check("both_served", {30'h0, fe_req, mem_req}, 32'h0);
      @(negedge clk);

      // Reset mid-BUSY_MEM
      bus_q.push_back('{30'h100, 4'b1111, 1'b0, 32'h0});
      ack_q.push_back('{100000, 32'h0, 1'b0});
      mem_req = 1; mem_addr = 32'h400; mem_width = WIDTH_W; mem_extend = 0; mem_write = 0;
      @(negedge clk);
      mem_req = 1'b0;
      @(negedge clk);
      check("busy_before_reset", {31'h0, bus_req}, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_ctl", {bus_req, bus_write, fe_ack, fe_error, mem_ack, mem_error, 26'h0}, 32'h0);
      check("async_rst_bus", {bus_be, 28'h0} | {2'b0, bus_addr}, 32'h0);
      check("async_rst_data", fe_data | mem_data_out | bus_wdata, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      // Late ack with nothing outstanding must not produce a response
      stray_ack = 1'b1;
      @(negedge clk);
      @(negedge clk);
      stray_ack = 1'b0;
      check("stray_ack_ignored", {30'h0, fe_ack, mem_ack}, 32'h0);
      fe_txn(30'h200, 2, 32'hA5A5A5A5, 1'b0);

      repeat (3) @(negedge clk);
      check("rsp_q_drained", rsp_q.size(), 32'h0);
      check("bus_q_drained", bus_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
